// File: rtl/cpu_pkg.sv
// Shared RV32I core types: immediate formats, controller states, datapath selects and opcodes.
// The TRAP state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package cpu_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
`ifdef CTRL_ILLEGAL_TRAP_EN
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
`else
    ST_WB     = 3'd4
`endif
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_TARGET = 2'd1,
    PC_JALR   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } alu_a_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    CLS_OP      = 4'd0,
    CLS_OPIMM   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd9
  } op_class_t;

endpackage

// File: rtl/ctrl_opdec.sv
// Combinational opcode decoder: instr[6:0] -> opcode class, immediate format and legality.
module ctrl_opdec
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output imm_type_t  imm_type,
  output logic       legal
);

  // Map each base opcode to its class and immediate format; OP carries no immediate.
  always_comb begin
    op_class = CLS_ILLEGAL;
    imm_type = IMM_I;
    legal    = 1'b1;
    case (opcode)
      OPC_OP:     op_class = CLS_OP;
      OPC_OPIMM:  op_class = CLS_OPIMM;
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_JALR:   op_class = CLS_JALR;
      OPC_STORE: begin
        op_class = CLS_STORE;
        imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        op_class = CLS_BRANCH;
        imm_type = IMM_B;
      end
      OPC_LUI: begin
        op_class = CLS_LUI;
        imm_type = IMM_U;
      end
      OPC_AUIPC: begin
        op_class = CLS_AUIPC;
        imm_type = IMM_U;
      end
      OPC_JAL: begin
        op_class = CLS_JAL;
        imm_type = IMM_J;
      end
      default: begin
        op_class = CLS_ILLEGAL;
        legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with imem/dmem req-ready handshakes.
// Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes (adds TRAP state and sticky illegal port).
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter imm_type_t RESET_IMM = IMM_I
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        ir_we,
  input  logic        br_taken,
  output imm_type_t   imm_type,
  output alu_a_sel_t  alu_a_sel,
  output logic        alu_b_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output wb_sel_t     wb_sel,
  output logic        pc_we,
  output pc_sel_t     pc_sel
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  ctrl_state_t state_r;
  op_class_t   cls_r;
  imm_type_t   imm_type_r;
  alu_a_sel_t  alu_a_sel_r;
  logic        alu_b_sel_r;
  logic        imem_req_r;
  logic        dmem_req_r;
  logic        dmem_we_r;
  logic        rf_we_r;
  wb_sel_t     wb_sel_r;
  logic        pc_we_r;
  pc_sel_t     pc_sel_r;
  logic        illegal_r;

  op_class_t   dec_cls_s;
  imm_type_t   dec_imm_s;
  logic        dec_legal_s;
  logic        br_exec_s;
  logic        store_done_s;
  logic        unused_instr_s;

  assign unused_instr_s = ^instr[31:7];

  ctrl_opdec u_opdec (
    .opcode   (instr[6:0]),
    .op_class (dec_cls_s),
    .imm_type (dec_imm_s),
    .legal    (dec_legal_s)
  );

  // State sequencing; every registered output is loaded with its value for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_FETCH;
      cls_r       <= CLS_OP;
      imm_type_r  <= RESET_IMM;
      alu_a_sel_r <= A_RS1;
      alu_b_sel_r <= 1'b0;
      imem_req_r  <= 1'b0;
      dmem_req_r  <= 1'b0;
      dmem_we_r   <= 1'b0;
      rf_we_r     <= 1'b0;
      wb_sel_r    <= WB_ALU;
      pc_we_r     <= 1'b0;
      pc_sel_r    <= PC_PLUS4;
      illegal_r   <= 1'b0;
    end else begin
      alu_a_sel_r <= A_RS1;
      alu_b_sel_r <= 1'b0;
      imem_req_r  <= 1'b0;
      dmem_req_r  <= 1'b0;
      dmem_we_r   <= 1'b0;
      rf_we_r     <= 1'b0;
      wb_sel_r    <= WB_ALU;
      pc_we_r     <= 1'b0;
      pc_sel_r    <= PC_PLUS4;
      case (state_r)
        ST_FETCH: begin
          // Ready is only honoured once our request is visible outside.
          if (imem_req_r && imem_ready) begin
            state_r <= ST_DECODE;
          end else begin
            imem_req_r <= 1'b1;
          end
        end
        ST_DECODE: begin
          cls_r <= dec_cls_s;
          if (dec_legal_s && (dec_cls_s != CLS_OP)) begin
            imm_type_r <= dec_imm_s;
          end else begin
            imm_type_r <= imm_type_r;
          end
          pc_we_r <= (dec_cls_s == CLS_BRANCH);
          case (dec_cls_s)
            CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_JALR: alu_b_sel_r <= 1'b1;
            CLS_AUIPC: begin
              alu_a_sel_r <= A_PC;
              alu_b_sel_r <= 1'b1;
            end
            CLS_LUI: begin
              alu_a_sel_r <= A_ZERO;
              alu_b_sel_r <= 1'b1;
            end
            default: alu_b_sel_r <= 1'b0;
          endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
          if (!dec_legal_s) begin
            state_r   <= ST_TRAP;
            illegal_r <= 1'b1;
          end else begin
            state_r <= ST_EXEC;
          end
`else
          state_r <= ST_EXEC;
`endif
        end
        ST_EXEC: begin
          case (cls_r)
            CLS_BRANCH: begin
              state_r    <= ST_FETCH;
              imem_req_r <= 1'b1;
            end
            CLS_LOAD, CLS_STORE: begin
              state_r    <= ST_MEM;
              dmem_req_r <= 1'b1;
              dmem_we_r  <= (cls_r == CLS_STORE);
            end
            default: begin
              state_r  <= ST_WB;
              rf_we_r  <= (cls_r != CLS_ILLEGAL);
              pc_we_r  <= 1'b1;
              wb_sel_r <= ((cls_r == CLS_JAL) || (cls_r == CLS_JALR)) ? WB_PC4 : WB_ALU;
              pc_sel_r <= (cls_r == CLS_JAL)  ? PC_TARGET :
                          (cls_r == CLS_JALR) ? PC_JALR : PC_PLUS4;
            end
          endcase
        end
        ST_MEM: begin
          if (!dmem_ready) begin
            dmem_req_r <= 1'b1;
            dmem_we_r  <= dmem_we_r;
          end else if (cls_r == CLS_STORE) begin
            state_r    <= ST_FETCH;
            imem_req_r <= 1'b1;
          end else begin
            state_r  <= ST_WB;
            rf_we_r  <= 1'b1;
            wb_sel_r <= WB_MEM;
            pc_we_r  <= 1'b1;
          end
        end
        ST_WB: begin
          state_r    <= ST_FETCH;
          imem_req_r <= 1'b1;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        ST_TRAP: state_r <= ST_TRAP;
`endif
        default: state_r <= ST_FETCH;
      endcase
    end
  end

  assign br_exec_s    = (state_r == ST_EXEC) && (cls_r == CLS_BRANCH);
  assign store_done_s = dmem_req_r && dmem_we_r && dmem_ready;

  // Branch outcome and store completion are the only paths from inputs to the PC controls.
  always_comb begin
    pc_we = pc_we_r | store_done_s;
    if (br_exec_s) begin
      pc_sel = br_taken ? PC_TARGET : PC_PLUS4;
    end else begin
      pc_sel = pc_sel_r;
    end
  end

  assign imem_req  = imem_req_r;
  assign ir_we     = imem_req_r & imem_ready;
  assign imm_type  = imm_type_r;
  assign alu_a_sel = alu_a_sel_r;
  assign alu_b_sel = alu_b_sel_r;
  assign dmem_req  = dmem_req_r;
  assign dmem_we   = dmem_we_r;
  assign rf_we     = rf_we_r;
  assign wb_sel    = wb_sel_r;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal   = illegal_r;
`else
  logic unused_illegal_s;
  assign unused_illegal_s = illegal_r;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: per-instruction cycle model built from the opcode rules, checked every cycle.
module tb_multicycle_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, br_taken = 1'b0;
  logic        imem_req, ir_we, alu_b_sel, dmem_req, dmem_we, rf_we, pc_we;
  imm_type_t   imm_type;
  alu_a_sel_t  alu_a_sel;
  wb_sel_t     wb_sel;
  pc_sel_t     pc_sel;
  logic        illegal;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_IMM(IMM_I)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we), .br_taken(br_taken),
    .imm_type(imm_type), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );
`ifndef CTRL_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  typedef struct {
    logic [31:0] ins;
    logic        iready, dready, br;
    logic        ireq, irwe, b, dreq, dwe, rfwe, pcwe, ill;
    logic [2:0]  imm;
    logic [1:0]  a, wb, pcs;
  } cyc_t;

  cyc_t       exp_q[$];
  logic [2:0] imm_cur;
  logic       ill_cur;
  int         n_checks = 0, n_err = 0, cyc = 0;
  int         lo_cnt, dq_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic cyc_t blank(input logic [31:0] ins);
    cyc_t c;
    c.ins = ins; c.iready = 1'b0; c.dready = 1'b0; c.br = 1'b0;
    c.ireq = 1'b0; c.irwe = 1'b0; c.b = 1'b0; c.dreq = 1'b0; c.dwe = 1'b0;
    c.rfwe = 1'b0; c.pcwe = 1'b0; c.ill = ill_cur;
    c.imm = imm_cur; c.a = 2'd0; c.wb = 2'd0; c.pcs = 2'd0;
    return c;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, from the architectural rules.
  task automatic gen(input logic [31:0] ins, input int wi, input int wd, input logic br, input logic noise);
    cyc_t c;
    logic [6:0] op;
    logic ld, st, bra, jal, jalr, lui, auipc, opimm, opr, legal;
    op = ins[6:0];
    ld = (op == 7'h03); st = (op == 7'h23); bra = (op == 7'h63); jal = (op == 7'h6F);
    jalr = (op == 7'h67); lui = (op == 7'h37); auipc = (op == 7'h17);
    opimm = (op == 7'h13); opr = (op == 7'h33);
    legal = ld | st | bra | jal | jalr | lui | auipc | opimm | opr;
    for (int i = 0; i < wi; i++) begin
      c = blank(ins); c.ireq = 1'b1; c.dready = noise; exp_q.push_back(c);
    end
    c = blank(ins); c.ireq = 1'b1; c.iready = 1'b1; c.irwe = 1'b1; exp_q.push_back(c);
    c = blank(ins); c.iready = noise; exp_q.push_back(c);
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (!legal) begin
      ill_cur = 1'b1;
      for (int i = 0; i < 20; i++) begin
        c = blank(ins); c.iready = 1'b1; exp_q.push_back(c);
      end
      return;
    end
`endif
    if (ld | opimm | jalr) imm_cur = 3'd0;
    else if (st) imm_cur = 3'd1;
    else if (bra) imm_cur = 3'd2;
    else if (lui | auipc) imm_cur = 3'd3;
    else if (jal) imm_cur = 3'd4;
    else imm_cur = imm_cur;
    c = blank(ins); c.br = br; c.dready = noise;
    c.b = opimm | ld | st | jalr | auipc | lui;
    c.a = auipc ? 2'd1 : (lui ? 2'd2 : 2'd0);
    if (bra) begin
      c.pcwe = 1'b1; c.pcs = br ? 2'd1 : 2'd0;
    end
    exp_q.push_back(c);
    if (bra) return;
    if (ld | st) begin
      for (int i = 0; i < wd; i++) begin
        c = blank(ins); c.dreq = 1'b1; c.dwe = st; exp_q.push_back(c);
      end
      c = blank(ins); c.dreq = 1'b1; c.dwe = st; c.dready = 1'b1; c.pcwe = st;
      exp_q.push_back(c);
      if (st) return;
    end
    c = blank(ins); c.iready = noise; c.rfwe = legal; c.pcwe = 1'b1;
    c.wb = ld ? 2'd1 : ((jal | jalr) ? 2'd2 : 2'd0);
    c.pcs = jal ? 2'd1 : (jalr ? 2'd2 : 2'd0);
    exp_q.push_back(c);
  endtask

  // Drive each modelled cycle at the falling edge and compare every output shortly after.
  task automatic play(input int n);
    cyc_t c;
    int k = 0;
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      c = exp_q.pop_front();
      @(negedge clk);
      instr = c.ins; imem_ready = c.iready; dmem_ready = c.dready; br_taken = c.br;
      #1;
      cyc++; k++;
      if (!imem_req) lo_cnt++;
      if (dmem_req) dq_cnt++;
      chk("imem_req", imem_req, c.ireq);
      chk("ir_we", ir_we, c.irwe);
      chk("imm_type", imm_type, c.imm);
      chk("alu_a_sel", alu_a_sel, c.a);
      chk("alu_b_sel", alu_b_sel, c.b);
      chk("dmem_req", dmem_req, c.dreq);
      chk("dmem_we", dmem_we, c.dwe);
      chk("rf_we", rf_we, c.rfwe);
      chk("wb_sel", wb_sel, c.wb);
      chk("pc_we", pc_we, c.pcwe);
      chk("pc_sel", pc_sel, c.pcs);
`ifdef CTRL_ILLEGAL_TRAP_EN
      chk("illegal", illegal, c.ill);
`endif
    end
  endtask

  task automatic run(input string nm, input logic [31:0] ins, input int wi, input int wd,
                     input logic br, input logic noise, input int exp_lo, input int exp_dq);
    lo_cnt = 0; dq_cnt = 0;
    gen(ins, wi, wd, br, noise);
    play(-1);
    chk({nm, "_idle_cycles"}, lo_cnt, exp_lo);
    chk({nm, "_dmem_cycles"}, dq_cnt, exp_dq);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_imem_req"}, imem_req, 32'd0);
    chk({nm, "_ir_we"}, ir_we, 32'd0);
    chk({nm, "_imm_type"}, imm_type, 32'd0);
    chk({nm, "_alu"}, {alu_a_sel, alu_b_sel}, 32'd0);
    chk({nm, "_dmem"}, {dmem_req, dmem_we}, 32'd0);
    chk({nm, "_rf_we"}, rf_we, 32'd0);
    chk({nm, "_wb_sel"}, wb_sel, 32'd0);
    chk({nm, "_pc"}, {pc_we, pc_sel}, 32'd0);
    chk({nm, "_illegal"}, illegal, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    imm_cur = 3'd0; ill_cur = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    release_reset();

    run("addi",      32'h00500093, 0, 0, 1'b0, 1'b0, 3, 0);
    run("addi_wait", 32'h00500093, 2, 0, 1'b1, 1'b1, 3, 0);
    run("lw",        32'h0000A103, 0, 3, 1'b0, 1'b0, 7, 4);
    run("beq_t",     32'h00208463, 0, 0, 1'b1, 1'b0, 2, 0);
    run("beq_nt",    32'h00208463, 1, 0, 1'b0, 1'b1, 2, 0);
    run("jal",       32'h008000EF, 0, 0, 1'b1, 1'b0, 3, 0);
    run("jalr",      32'h000080E7, 0, 0, 1'b0, 1'b0, 3, 0);
    run("lui",       32'h123450B7, 0, 0, 1'b0, 1'b1, 3, 0);
    run("add",       32'h002081B3, 0, 0, 1'b0, 1'b0, 3, 0);
    run("auipc",     32'h00001097, 0, 0, 1'b0, 1'b0, 3, 0);
    run("sw",        32'h0020A023, 0, 1, 1'b0, 1'b1, 4, 2);

    // Reset while a store is stalled in memory.
    gen(32'h0020A023, 0, 5, 1'b0, 1'b0);
    play(5);
    chk("mid_mem_dmem_req_before", dmem_req, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_mem_reset");
    exp_q.delete();
    imm_cur = 3'd0;
    @(negedge clk);
    #1 chk("held_reset_imem_req", imem_req, 32'd0);
    release_reset();
    #1 chk("first_cycle_imem_req", imem_req, 32'd1);
    run("addi_after_reset", 32'h00500093, 0, 0, 1'b0, 1'b0, 3, 0);

`ifdef CTRL_ILLEGAL_TRAP_EN
    run("illegal", 32'h0000007F, 0, 0, 1'b0, 1'b0, 21, 0);
`else
    run("illegal", 32'h0000007F, 0, 0, 1'b0, 1'b0, 3, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back states. It decodes the opcode to drive the immediate generator's `imm_type`, the ALU operand selects, the PC update and the register-file write enable. It also runs the req/ready handshakes to instruction and data memory, and sits between the instruction register and the shared datapath.

## Interface
Parameters:
- `RESET_IMM` — default `IMM_I`; value of `imm_type` out of reset.

Ports:
- `clk`  in  1  — single core clock.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `instr`  in  32  — instruction register contents; valid from DECODE onward.
- `imem_req`  out  1  — instruction fetch request.
- `imem_ready`  in  1  — fetch data valid this cycle.
- `ir_we`  out  1  — load the instruction register.
- `br_taken`  in  1  — ALU branch-compare result; sampled in EXEC.
- `imm_type`  out  `imm_type_t`  — immediate format select to the immediate generator.
- `alu_a_sel`  out  `alu_a_sel_t`  — ALU operand A select: `A_RS1`, `A_PC` or `A_ZERO`.
- `alu_b_sel`  out  1  — ALU operand B select: 0 = rs2, 1 = imm.
- `dmem_req`  out  1  — data memory request.
- `dmem_we`  out  1  — data memory write (store).
- `dmem_ready`  in  1  — data access complete.
- `rf_we`  out  1  — register-file write enable.
- `wb_sel`  out  `wb_sel_t`  — write-back source: `WB_ALU`, `WB_MEM` or `WB_PC4`.
- `pc_we`  out  1  — PC write enable.
- `pc_sel`  out  `pc_sel_t`  — next-PC source: `PC_PLUS4`, `PC_TARGET` (pc+imm) or `PC_JALR` ((rs1+imm)&~1).
- `illegal`  out  1  — sticky illegal-instruction flag; present only with the macro in Configuration.

## Operation
States are FETCH, DECODE, EXEC, MEM, WB, and TRAP (TRAP exists only with the macro).

- **FETCH**
  - `imem_req`=1 until `imem_ready`.
  - `ir_we`=`imem_ready`.
  - On `imem_ready`, go to DECODE.
- **DECODE** (1 cycle)
  - Register the opcode class from `instr[6:0]`.
  - Register `imm_type`:
    - I for OP-IMM, LOAD, JALR
    - S for STORE
    - B for BRANCH
    - U for LUI, AUIPC
    - J for JAL
    - OP leaves `imm_type` unchanged
  - `imm_type` is held stable until the next DECODE.
- **EXEC** (1 cycle); ALU operand selects by class:
  - OP: A_RS1 / rs2.
  - OP-IMM, LOAD, STORE, JALR: A_RS1 / imm.
  - AUIPC: A_PC / imm.
  - LUI: A_ZERO / imm.
  - BRANCH: A_RS1 / rs2.
- **EXEC** next state:
  - BRANCH: `pc_we`=1 and `pc_sel`=`br_taken` ? `PC_TARGET` : `PC_PLUS4`, then go to FETCH.
  - LOAD, STORE: go to MEM.
  - All others: go to WB.
- **MEM**
  - `dmem_req`=1, with `dmem_we`=1 for STORE, held until `dmem_ready`.
  - STORE: on ready, `pc_we`=1 with `PC_PLUS4`, then go to FETCH.
  - LOAD: on ready, go to WB.
- **WB** (1 cycle)
  - `rf_we`=1.
  - `wb_sel`: `WB_MEM` for LOAD, `WB_PC4` for JAL/JALR, `WB_ALU` otherwise.
  - `pc_we`=1 with `pc_sel`: `PC_TARGET` for JAL, `PC_JALR` for JALR, `PC_PLUS4` otherwise.
  - Next state: FETCH.
- All select outputs not listed for a state hold 0 / first enum value.
- `rf_we`, `pc_we`, `ir_we`, `imem_req` and `dmem_req` are never asserted outside the states named above.

## Timing
- **Reset:**
  - State = FETCH and `imm_type`=`RESET_IMM`.
  - Every other output is 0 or the first enum value, including `illegal`=0.
  - Assertion mid-access drops `imem_req`/`dmem_req` asynchronously.
  - The first `imem_req` is asserted in the first cycle after deassertion.
- **Cycles per instruction with zero-wait memory** (ready in the same cycle as req):
  - ALU, LUI, AUIPC, JAL, JALR: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH: 3.
- Each wait cycle adds 1 to the count.
- Handshakes: req stays high and the state is held until ready is sampled high. Ready while req is low is ignored.
- Outputs are decoded from the registered state and opcode class. Only `ir_we` and the MEM exit depend combinationally on ready.
- `br_taken` is sampled only in EXEC.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE goes to TRAP.
  - In TRAP, `illegal`=1 (sticky), all enables are 0 and no further fetch occurs until reset.
- `CTRL_ILLEGAL_TRAP_EN` undefined:
  - The `illegal` port and the TRAP state are absent.
  - An unknown opcode executes as a NOP: EXEC→WB with `rf_we`=0, `pc_we`=1 and `PC_PLUS4`.

## Structure
- Add to `cpu_pkg`:
  - `ctrl_state_t`, `pc_sel_t`, `alu_a_sel_t` and `wb_sel_t` enums.
  - Opcode localparams (`OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_JALR`, `OPC_BRANCH`, `OPC_LOAD`, `OPC_STORE`, `OPC_OPIMM`, `OPC_OP`).
  - The `op_class_t` enum.
- `imm_type_t` is reused from `cpu_pkg` unchanged.
- One sub-module, `ctrl_opdec`: combinational `instr[6:0]` → `op_class_t`, `imm_type` and a legal flag, instantiated once in DECODE.

## Test plan
- **Reset:** hold `rst_n`=0 mid-MEM with `dmem_req`=1 → all outputs 0 and `imm_type`=IMM_I immediately; `imem_req`=1 in the first cycle after release.
- **ADDI** 0x00500093 with zero-wait memory → states F,D,E,W in 4 cycles; `imm_type`=IMM_I, `alu_b_sel`=1, `rf_we`=1 in W, `pc_sel`=PC_PLUS4.
- **LW** 0x0000A103 with `dmem_ready` delayed 3 cycles → `dmem_req` high 4 cycles with `dmem_we`=0; WB uses `WB_MEM`; total 8 cycles.
- **BEQ** 0x00208463:
  - `br_taken`=1 → `imm_type`=IMM_B, `pc_we`=1 with PC_TARGET in EXEC, no `rf_we`, 3 cycles.
  - `br_taken`=0 → PC_PLUS4.
- **JAL** 0x008000EF → `imm_type`=IMM_J, WB with `wb_sel`=WB_PC4 and `pc_sel`=PC_TARGET. **SW** 0x0020A023 → IMM_S, `dmem_we`=1, no `rf_we`.
- **Opcode 0x7F:**
  - With `CTRL_ILLEGAL_TRAP_EN` → TRAP, `illegal`=1, `imem_req` stays 0 for 20 cycles.
  - Without it → NOP, PC+4, `rf_we`=0.
